m_spi_tx_fifo: RTL
==================

Name: m_spi_tx_fifo

Overview:
- Parametrised successor to the single-byte SPI sender used by the ST7789 display path.
- Adds a command/data FIFO, chip select, configurable SCL rate, configurable word width and clock polarity, and back-to-back bursts with CS held low.
- Sits between the display controller (which pushes {DC, data} words) and the panel pins.

Parameters:
- DATA_W, 8, payload bits per frame; sent MSB first.
- FIFO_DEPTH, 16, number of FIFO entries; must be a power of 2, ≥2.
- CLK_DIV, 1, length of each SCL half-period in w_clk cycles; must be ≥1.
- CPOL, 1, SCL idle level (1 = SPI mode 2, 0 = mode 0).

Ports:
- w_clk  in  1  system clock (100 MHz).
- w_rst  in  1  synchronous reset, active-high.
- en  in  1  push strobe; d_in is written when en=1 and full=0.
- d_in  in  DATA_W+1  {DC bit, payload}; DC=0 marks a command, DC=1 marks data.
- full  out  1  FIFO full (registered).
- empty  out  1  FIFO empty (registered).
- level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- overflow  out  1  sticky flag; set when a push is attempted while full.
- busy  out  1  FIFO non-empty or frame in progress.
- SDA  out  1  serial data, equal to the shift-register MSB.
- SCL  out  1  serial clock.
- DC  out  1  data/command, latched per frame.
- CS  out  1  chip select, active-low.

Behaviour:
- Reset values (at the w_rst edge, regardless of state): FIFO cleared; level=0, empty=1, full=0, overflow=0, busy=0, SCL=CPOL, SDA=0, DC=0, CS=1; state=IDLE.
- Reset mid-frame: the frame is aborted with no partial completion; outputs take reset values on the next edge.
- Push rule: a push is accepted iff en=1 and the registered full=0 at that edge.
  - A rejected push sets overflow and leaves FIFO contents unchanged.
  - Push and pop on the same edge leave level unchanged.
  - full/empty/level reflect the post-edge occupancy.
  - Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, SHIFT.
- IDLE:
  - Stays here while empty=1; CS=1, SCL=CPOL.
  - If empty=0: pop the head; load payload into the shift register; DC<=head[DATA_W]; CS<=0; reset counters; go to SHIFT.
  - A push into an empty FIFO at edge t is popped at edge t+1.
- SHIFT: each bit lasts 2*CLK_DIV cycles.
  - First CLK_DIV cycles: SCL=CPOL.
  - Next CLK_DIV cycles: SCL=~CPOL.
  - The slave samples on the CPOL→~CPOL edge, so SDA is stable for CLK_DIV cycles before it.
  - At the end of each bit, the shift register shifts left with zero fill and SCL returns to CPOL.
- End of last bit (after DATA_W bits, 2*CLK_DIV*DATA_W cycles from load):
  - If empty=0: pop the next word on that same edge and stay in SHIFT. CS stays 0; DC updates; no gap cycles (burst).
  - Else: CS<=1, SDA<=0, go to IDLE.
- First leading SCL edge occurs CLK_DIV cycles after the load edge.
- busy = ~empty | (state==SHIFT).
- DC changes only at load edges and is constant for the whole frame.
- Pushes during a frame never disturb the frame in flight.
- level never exceeds FIFO_DEPTH; overflow clears only on w_rst.

Test Plan:
- Single command, defaults: push {0,0x2A} -> next edge CS=0, DC=0; SDA bits 0,0,1,0,1,0,1,0 each held 2 cycles; SCL falls at load+1; CS=1 at load+16; busy=0 afterwards.
- Burst, defaults: push {0,0x2C},{1,0xF8},{1,0x00} on consecutive cycles -> CS low continuously for 48 cycles; DC sequence 0,1,1 switches exactly at 16-cycle boundaries; level peaks at 2.
- Overflow: with the engine stalled (w_rst low, CLK_DIV=4), push 18 words back-to-back -> first word popped; level reaches 16, full=1; the 18th push sets overflow=1; all 17 accepted words transmitted in order.
- Timing, CLK_DIV=3, CPOL=0: push {1,0x81} -> SCL idles 0; each bit lasts 6 cycles with SCL high in the second 3 cycles; SDA=1 for bit 0 and bit 7 only; frame lasts 48 cycles.
- Reset mid-frame: assert w_rst for 1 cycle after 5 bits of 0xA5 with 3 words queued -> next edge CS=1, SCL=CPOL, level=0, empty=1; no further SCL edges.
- Simultaneous events: at the last-bit edge, with level=1 and a new push -> pop and push on the same edge; level stays 1; CS stays 0 across both frames.

Source files
------------

// File: rtl/m_spi_tx_fifo.sv
// m_spi_tx_fifo: FIFO-fed SPI transmitter for the ST7789 display path.
// The display controller pushes {DC, payload} words; the engine pops them and
// shifts each payload out MSB first with chip select held low across bursts.
// Handshake: a push is taken on any edge where en=1 and the registered full=0.
// A push attempted while full is dropped and latches the sticky overflow flag.
module m_spi_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 1,
  parameter int CPOL       = 1
) (
  input  logic                            w_clk,
  input  logic                            w_rst,
  input  logic                            en,
  input  logic [DATA_W:0]                 d_in,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
  output logic                            overflow,
  output logic                            busy,
  output logic                            SDA,
  output logic                            SCL,
  output logic                            DC,
  output logic                            CS
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PH_W  = $clog2(2 * CLK_DIV);
  localparam int BC_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic             IDLE_LVL = (CPOL != 0);
  localparam logic [PH_W-1:0]  PH_LEAD  = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_DIV - 1);
  localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(DATA_W - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t              state, state_next;
  logic [DATA_W:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0]    count, count_next;
  logic                full_q, empty_q, ovf_q;
  logic                push, pop, bit_end, frame_end;
  logic [PH_W-1:0]     ph;
  logic [BC_W-1:0]     bit_cnt;
  logic [DATA_W-1:0]   sr;
  logic                scl_q, dc_q, cs_q;

  assign push = en & ~full_q;

  // Next state and pop decision: pop when idle with data, or at the end of a
  // frame so the next word starts on the same edge (burst, no gap).
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    bit_end    = 1'b0;
    frame_end  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty_q) begin
          pop        = 1'b1;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bit_end   = (ph == PH_LAST);
        frame_end = bit_end && (bit_cnt == BIT_LAST);
        if (frame_end) begin
          if (!empty_q) pop = 1'b1;
          else          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Occupancy after this edge; same-edge push and pop cancel out.
  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (pop && !push) count_next = count - 1'b1;
  end

  // FIFO storage; stale entries are harmless because reset clears the pointers.
  always_ff @(posedge w_clk) begin
    if (push && !w_rst) mem[wr_ptr] <= d_in;
  end

  // FIFO pointers, registered flags and the sticky overflow.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_next;
      full_q  <= (count_next == LVL_FULL);
      empty_q <= (count_next == '0);
      if (en && full_q) ovf_q <= 1'b1;
    end
  end

  // Shift engine: phase counter splits each bit into an idle-level half and
  // an active half; the shift register moves at the end of every bit.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state   <= S_IDLE;
      ph      <= '0;
      bit_cnt <= '0;
      sr      <= '0;
      scl_q   <= IDLE_LVL;
      dc_q    <= 1'b0;
      cs_q    <= 1'b1;
    end else begin
      state <= state_next;
      if (pop) begin
        sr      <= mem[rd_ptr][DATA_W-1:0];
        dc_q    <= mem[rd_ptr][DATA_W];
        cs_q    <= 1'b0;
        ph      <= '0;
        bit_cnt <= '0;
        scl_q   <= IDLE_LVL;
      end else if (state == S_SHIFT) begin
        if (frame_end) begin
          cs_q    <= 1'b1;
          sr      <= '0;
          scl_q   <= IDLE_LVL;
          ph      <= '0;
          bit_cnt <= '0;
        end else if (bit_end) begin
          sr      <= sr << 1;
          scl_q   <= IDLE_LVL;
          ph      <= '0;
          bit_cnt <= bit_cnt + 1'b1;
        end else begin
          ph <= ph + 1'b1;
          if (ph == PH_LEAD) scl_q <= ~IDLE_LVL;
        end
      end
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = count;
  assign overflow = ovf_q;
  assign busy     = ~empty_q | (state == S_SHIFT);
  assign SDA      = sr[DATA_W-1];
  assign SCL      = scl_q;
  assign DC       = dc_q;
  assign CS       = cs_q;

endmodule
